// File: rtl/cpu_debug_ctrl_pkg.sv
// Shared definitions for the CPU debug controller: FSM state encoding
// (also decoded by the board top for the state LEDs), PC width and the
// breakpoint compare helper.
package cpu_debug_ctrl_pkg;

  localparam int PC_W = 9;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    STEP  = 2'd1,
    RUN   = 2'd2,
    BREAK = 2'd3
  } dbg_state_t;

  // True when the breakpoint is armed and the given PC is the breakpoint PC.
  function automatic logic bp_match(input logic            en,
                                    input logic [PC_W-1:0] addr,
                                    input logic [PC_W-1:0] pc_val);
    return en && (addr == pc_val);
  endfunction

endpackage

// File: rtl/cpu_debug_ctrl_key_debounce.sv
// Pushbutton front end: 2-FF synchroniser, level debouncer and a one-cycle
// pulse on each accepted press (stable level falling 1 -> 0). The key is
// active-low, so everything idles high.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d1_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the raw key into the clock domain; idle level is released (1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after it has differed from the stable level for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else if (sync2_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q    <= '0;
      stable_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Delayed copy of the stable level for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d1_q <= 1'b1;
    end else begin
      stable_d1_q <= stable_q;
    end
  end

  assign press = stable_d1_q & ~stable_q;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Run/step/breakpoint controller producing the CPU core clock enable.
// HALT freezes the core, STEP issues one enable per key press, RUN issues
// an enable every RUN_DIV cycles until the breakpoint PC would execute,
// at which point BREAK freezes the core with bp_hit raised.
module cpu_debug_ctrl
  import cpu_debug_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int RUN_DIV         = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_step_n,
  input  logic            run_sw,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc,
  input  logic            clr_cnt,
  output logic            cpu_en,
  output logic [1:0]      state,
  output logic            bp_hit,
  output logic [15:0]     step_count
);

  localparam int PRESC_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(RUN_DIV - 1);

  dbg_state_t       state_q;
  dbg_state_t       state_d;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_d;
  logic             cpu_en_q;
  logic             cpu_en_d;
  logic             run_sync1_q;
  logic             run_s;
  logic             press;
  logic [PC_W-1:0]  exec_pc;
  logic [15:0]      count_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk  (clk),
    .reset(reset),
    .key_n(key_step_n),
    .press(press)
  );

  // Run switch only needs synchronising; its level is used directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_sync1_q <= 1'b0;
      run_s       <= 1'b0;
    end else begin
      run_sync1_q <= run_sw;
      run_s       <= run_sync1_q;
    end
  end

  // cpu_en is registered, so a decision made now lands one cycle later.
  // If an enable is on the wire this cycle the core will have advanced
  // one instruction by then, so the breakpoint is compared against the
  // PC that the next enable would actually execute. This also keeps a
  // step off a breakpoint from re-triggering on the PC it just executed.
  assign exec_pc = cpu_en_q ? (pc + 1'b1) : pc;

  // FSM, prescaler and enable registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= HALT;
      presc_q  <= '0;
      cpu_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      cpu_en_q <= cpu_en_d;
    end
  end

  // Next-state and enable decode. The prescaler defaults to zero, so it
  // is already cleared on any entry into RUN and restarts after each tick.
  // Presses outside HALT/BREAK fall through unhandled and are lost.
  always_comb begin
    state_d  = state_q;
    presc_d  = '0;
    cpu_en_d = 1'b0;
    case (state_q)
      HALT: begin
        if (run_s) begin
          state_d = RUN;
        end else if (press) begin
          state_d = STEP;
        end
      end
      STEP: begin
        cpu_en_d = 1'b1;
        state_d  = run_s ? RUN : HALT;
      end
      RUN: begin
        if (!run_s) begin
          state_d = HALT;
        end else if (presc_q == PRESC_MAX) begin
          if (bp_match(bp_en, bp_addr, exec_pc)) begin
            state_d = BREAK;
          end else begin
            cpu_en_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      BREAK: begin
        if (!run_s) begin
          state_d = HALT;
        end else if (press) begin
          state_d = STEP;
        end
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  // Count issued enables; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr_cnt) begin
      count_q <= '0;
    end else if (cpu_en_q) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign cpu_en     = cpu_en_q;
  assign state      = state_q;
  assign bp_hit     = (state_q == BREAK);
  assign step_count = count_q;

endmodule
